// File: rtl/unary_expander127.sv
// -----------------------------------------------------------------------------
// unary_expander127
//   Sequential count-to-thermometer decoder. Accepts a count k over a
//   valid/ready handshake and builds a W-bit word with exactly k ones,
//   LSB-first, one bit per clock. Each bit is streamed serially as it is built.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_count   requested number of ones k (CW bits)
//   in_valid   in_count valid
//   in_ready   block can accept a count (IDLE)
//   ser_bit    serial bit j of the word, 0 when ser_valid is low
//   ser_valid  ser_bit meaningful (SHIFT)
//   out_word   completed thermometer word (qualify with out_valid)
//   out_valid  out_word complete and held (DONE)
//   out_ready  consumer accepts out_word
//   busy       high in SHIFT or DONE
// -----------------------------------------------------------------------------
module unary_expander127 #(
  parameter int n = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [n:0]             in_count,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   ser_bit,
  output logic                   ser_valid,
  output logic [2**(n+1)-2:0]    out_word,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int W  = 2**(n+1) - 1;
  localparam int CW = n + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   k_reg;
  logic [CW-1:0]   idx;
  logic [W-1:0]    sh;
  logic            bit_now;

  // Current thermometer bit; only meaningful while shifting.
  assign bit_now = (state == SHIFT) && (idx < k_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k_reg <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            k_reg <= in_count;
            idx   <= '0;
            sh    <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // New bit enters at the MSB; after W shifts bit 0 sits in sh[0].
          sh <= {bit_now, sh[W-1:1]};
          if (idx == CW'(W-1)) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode registered state only.
  assign in_ready  = (state == IDLE);
  assign ser_valid = (state == SHIFT);
  assign ser_bit   = bit_now;
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT) || (state == DONE);
  assign out_word  = sh;

endmodule

// File: tb/tb_unary_expander127.sv
// -----------------------------------------------------------------------------
// tb_unary_expander127
//   Randomized self-checking bench for unary_expander127. Expected words come
//   from arithmetic ((1<<k)-1), popcount from a bit-counting loop.
// -----------------------------------------------------------------------------
module tb_unary_expander127;

  localparam int W = 127;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [6:0]     in_count;
  logic           in_valid;
  logic           in_ready;
  logic           ser_bit;
  logic           ser_valid;
  logic [W-1:0]   out_word;
  logic           out_valid;
  logic           out_ready;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;

  unary_expander127 #(.n(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_count  (in_count),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] therm(input int k);
    logic [127:0] t;
    t = (128'd1 << k) - 128'd1;
    return t[W-1:0];
  endfunction

  function automatic int popcnt(input logic [W-1:0] v);
    int c = 0;
    for (int i = 0; i < W; i++) if (v[i]) c++;
    return c;
  endfunction

  // One complete word. Called at a negedge; returns at a negedge in IDLE.
  // hold: cycles out_ready is held low after out_valid rises.
  // keep_valid: keep in_valid high with next_k presented after the accept.
  task automatic do_word(input int k, input int hold, input bit keep_valid,
                         input int next_k, input bit detail);
    logic [W-1:0] ser_vec;
    logic [W-1:0] exp_w;
    int           sv_cnt, ser_ones, bad_hold;
    int           waited;
    exp_w  = therm(k);
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    in_count  = 7'(k);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);                       // cycle 1
    if (keep_valid) in_count = 7'(next_k);
    else            in_valid = 1'b0;
    ser_vec = '0; sv_cnt = 0; ser_ones = 0;
    for (int j = 0; j < W; j++) begin     // cycle j+1
      if (ser_valid) sv_cnt++;
      ser_vec[j] = ser_bit;
      if (ser_bit) ser_ones++;
      if (detail && out_valid) chk("out_valid_early", j + 1, 128);
      @(negedge clk);
    end
    // cycle 128
    chk("ser_valid_cycles", sv_cnt, W);
    chk("ser_bits", ser_vec, exp_w);
    chk("ser_ones", ser_ones, k);
    chk("out_valid_128", out_valid, 1);
    chk("out_word", out_word, exp_w);
    chk("popcount", popcnt(out_word), k);
    if (detail) begin
      chk("done_in_ready", in_ready, 0);
      chk("done_busy", busy, 1);
      chk("done_ser_valid", ser_valid, 0);
      chk("done_ser_bit", ser_bit, 0);
    end
    if (hold > 0) begin
      bad_hold = 0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (out_word !== exp_w || !out_valid || in_ready) bad_hold++;
      end
      chk("hold_stable", bad_hold, 0);
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("out_valid_1cyc", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    if (detail) chk("idle_busy", busy, 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; in_count = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_ser_bit", ser_bit, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-SHIFT with in_valid/out_ready asserted during reset.
    in_count = 7'd50; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (39) @(negedge clk);
    chk("mid_shift_busy", busy, 1);
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_word", out_word, 0);
    chk("mrst_ser_valid", ser_valid, 0);
    chk("mrst_busy", busy, 0);
    do_word(3, 0, 1'b0, 0, 1'b1);

    // Boundary and mid counts, out_ready tied high.
    do_word(0, 0, 1'b0, 0, 1'b1);
    do_word(127, 0, 1'b0, 0, 1'b1);
    do_word(64, 0, 1'b0, 0, 1'b1);
    do_word(1, 0, 1'b0, 0, 1'b1);
    do_word(126, 0, 1'b0, 0, 1'b1);

    // Backpressure with a pending k=9 presented throughout.
    do_word(5, 10, 1'b1, 9, 1'b1);
    do_word(9, 0, 1'b0, 0, 1'b1);

    // Reset while in DONE.
    in_count = 7'd20; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (W + 2) @(negedge clk);
    chk("pre_rst_done", out_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("drst_out_valid", out_valid, 0);
    chk("drst_out_word", out_word, 0);

    // Random round trip.
    for (int r = 0; r < 200; r++) begin
      k = int'($urandom_range(127, 0));
      do_word(k, int'($urandom_range(3, 0)), 1'b0, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/unary_expander127.md
# unary_expander127

Sequential count-to-vector decoder: the inverse of the 127-bit ones counter. It accepts a 7-bit count k (0..127) over a valid/ready handshake and builds the 127-bit thermometer word with exactly k ones, LSB-first. It builds the word one bit per clock and streams each bit serially as it is built. It sits on the generator side of the ones-counter datapath, producing test and stimulus vectors whose popcount equals the requested count.

## Interface
- n, default 6: size parameter. Word width W = 2**(n+1)-1 = 127; count width CW = n+1 = 7.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
- in_count  input  CW  requested number of ones k.
- in_valid  input  1  in_count valid.
- in_ready  output  1  block can accept a count.
- ser_bit  output  1  current serial bit, bit index j of the word.
- ser_valid  output  1  ser_bit is meaningful this cycle.
- out_word  output  W  completed thermometer word.
- out_valid  output  1  out_word complete and held.
- out_ready  input  1  consumer accepts out_word.
- busy  output  1  high in SHIFT or DONE.

## Operation
- Registers:
  - state: IDLE, SHIFT, DONE.
  - k_reg (CW bits).
  - idx (CW bits, 0..W-1).
  - sh (W bits).
- Word rule: out_word[i] = 1 iff i < k, so popcount(out_word) = k.
  - k = 0 gives all zeros.
  - k = 127 gives all ones.
  - The count cannot exceed W, so no saturation logic is needed.
- IDLE:
  - in_ready = 1.
  - On in_valid at a clock edge: k_reg <= in_count, idx <= 0, sh <= 0, state <= SHIFT.
- SHIFT:
  - ser_valid = 1; ser_bit = (idx < k_reg), an unsigned compare.
  - At each edge: sh <= {ser_bit, sh[W-1:1]} (right shift, new bit into the MSB), and idx <= idx + 1.
  - When idx = W-1: state <= DONE and idx <= 0. idx never reaches 127, so there is no wrap.
- DONE:
  - out_valid = 1; out_word = sh. After W shifts, bit 0 emitted lands in sh[0].
  - On out_ready at an edge: state <= IDLE. sh is retained until the next accept.
- in_ready = 0 in SHIFT and DONE. in_valid is ignored there; the count is not queued.
- out_word is driven from sh in all states. Consumers must qualify it with out_valid.
- ser_bit is forced to 0 when ser_valid = 0.

## Timing
- Reset (rst_n = 0 at an edge) forces state IDLE and k_reg, idx, sh = 0. This includes reset mid-SHIFT and mid-DONE, and any in_valid or out_ready sampled in the same cycle is ignored.
- Output values after reset: in_ready = 1, ser_valid = 0, ser_bit = 0, out_valid = 0, out_word = 0, busy = 0.
- Latency, with the accept edge at cycle 0:
  - ser_valid is high in cycles 1..127, bit j appearing in cycle j+1.
  - out_valid rises in cycle 128.
- Throughput: minimum 129 cycles per word (accept, 127 shifts, DONE for at least one cycle with out_ready = 1).
- out_ready high on the first DONE cycle: out_valid lasts exactly 1 cycle and in_ready returns the next cycle.
- out_ready low: DONE holds indefinitely; out_word and out_valid stay stable.
- in_valid during DONE, even with out_ready asserted, is not accepted in that cycle. The next accept happens in IDLE.
- All outputs are decoded from registers only; there are no combinational input-to-output paths.

## Test plan
- Reset mid-SHIFT:
  - Stimulus: accept k=50, run 40 cycles, pulse rst_n low for 1 cycle.
  - Required: the next cycle shows in_ready=1, out_word=0, ser_valid=0, busy=0. A fresh k=3 then gives out_word=0x7.
- Boundary counts, out_ready tied high:
  - k=0 gives out_word = all zeros and ser_bit = 0 for all 127 cycles.
  - k=127 gives out_word = all ones and ser_bit = 1 for all 127 cycles.
  - out_valid rises exactly 128 cycles after the accept and lasts 1 cycle.
- Mid count k=64:
  - out_word[63:0] all ones, out_word[126:64] all zeros.
  - ser_bit = 1 in cycles 1..64 and 0 in cycles 65..127.
- Consumer backpressure:
  - Stimulus: k=5, out_ready held low for 10 cycles after out_valid rises; in_valid=1 with k=9 presented throughout.
  - Required: out_word stays 0x1F and in_ready stays 0 during the hold. After out_ready, IDLE accepts k=9 and the result is 0x1FF.
- Round trip with the ones counter:
  - Stimulus: 200 random k in 0..127, with out_word fed to the 127-bit ones counter.
  - Required: the counter output equals k for every word, and the serial bit count equals k.
